slot_availability_exit: RTL
===========================

# slot_availability_exit

Exit-side counterpart of the parking slot availability check. Holds the live per-flat occupancy bitmap and accepts one exit request at a time from the exit gate keypad. For each request it verifies the password result and that the flat's slot is occupied, then frees the slot and times the exit gate opening. The entry side reports each granted entry through a mark port so that one bitmap serves both gates.

## Interface
- N, `parking_slots, highest flat number; slots indexed 0..N (N+1 slots)
- GATE_CYCLES, 4, cycles gate_open stays high after a release (must be ≥1)
- FW, $clog2(N)+1 (derived, not overridable), flat-number width
- CW, $clog2(N+2) (derived), occupied-count width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- entry_mark  in  1  one-cycle pulse: entry side admitted a vehicle for entry_flat
- entry_flat  in  FW  flat whose slot becomes occupied
- exit_req  in  1  exit request valid
- exit_flat  in  FW  flat number of exiting vehicle
- pwd_flag  in  1  password verified for this request; sampled with exit_req
- exit_ready  out  1  high when a request can be accepted
- exit_ok  out  1  one-cycle pulse: slot freed
- exit_reject  out  1  one-cycle pulse: request refused
- gate_open  out  1  exit gate open level
- occupied_count  out  CW  number of occupied slots

## Operation
- State register: IDLE, CHECK, RELEASE, REJECT, GATE. Outputs are Moore decodes of the state: exit_ready=IDLE, exit_ok=RELEASE, exit_reject=REJECT, gate_open=GATE.
- Reset: state IDLE, bitmap all 0, occupied_count 0, gate counter 0, captured flat/pwd 0. While rst is high, exit_req and entry_mark are ignored.
- IDLE: if exit_req, capture exit_flat and pwd_flag, then go to CHECK. Otherwise stay in IDLE.
- CHECK: evaluate the captured request against the current bitmap value. The bitmap is read before any same-cycle update.
  - Go to REJECT if pwd=0, or flat>N, or the slot bit is 0.
  - Otherwise go to RELEASE.
- RELEASE: clear the slot bit, decrement occupied_count, load the gate counter with GATE_CYCLES-1, go to GATE.
- REJECT: no bitmap change, go to IDLE.
- GATE: counter decrements each cycle. When the counter is 0, go to IDLE.
- entry_mark, accepted in any state:
  - If entry_flat≤N and the bit is 0: set the bit and increment occupied_count.
  - If the bit is already 1 or entry_flat>N: ignored.
- Simultaneous entry_mark and RELEASE on different slots: both take effect, net count change 0.
- Simultaneous entry_mark and RELEASE on the same slot: set wins. The bit ends at 1, count is unchanged, exit_ok still pulses.
- occupied_count never wraps; its value is always the popcount of the bitmap.

## Timing
- Request accepted at edge E0, with exit_req high while exit_ready is high.
  - Cycle 1: CHECK.
  - Cycle 2: exit_ok or exit_reject high for exactly one cycle.
  - Release path: bit cleared and count updated at the end of cycle 2. gate_open is high for cycles 3..2+GATE_CYCLES. exit_ready returns in cycle 3+GATE_CYCLES.
  - Reject path: exit_ready returns in cycle 3.
- exit_req while not ready is ignored and not queued. The requester must hold exit_req until exit_ready is seen.
- entry_mark effect is visible in the bitmap and count one cycle after the pulse.
- rst asserted mid-request (any state, including GATE): next cycle is IDLE with all outputs 0, exit_ready 1, and bitmap cleared.

## Test plan
- N=8, G=4. Reset, then entry_mark flat 3. Request flat 3 with pwd=1 -> exit_ok in cycle 2; gate_open for 4 cycles; count goes 1→0; ready in cycle 7.
- Request flat 5 (empty) with pwd=1 -> exit_reject in cycle 2; no gate_open; count unchanged; ready in cycle 3.
- Mark flat 2, then request flat 2 with pwd=0 -> reject; bit 2 stays 1; count stays 1.
- Request flat 9 (>N), and entry_mark flat 9 -> both ignored or rejected; count 0.
- Slots 1 and 4 occupied. Exit flat 1 while entry_mark flat 6 lands in the RELEASE cycle -> count stays 2; bits 4 and 6 set. Repeat with same-slot mark -> bit stays 1, exit_ok still pulses.
- rst during GATE cycle 2 -> gate_open 0 next cycle; count 0; exit_ready 1. Also check that exit_req during GATE is not accepted.

Source files
------------

// File: rtl/slot_availability_exit.sv
// Exit-side parking slot availability: owns the occupancy bitmap shared with
// the entry gate, validates exit requests, frees slots and times the exit gate.
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

module slot_availability_exit #(
   parameter int N           = `PARKING_SLOTS,
   parameter int GATE_CYCLES = 4,
   localparam int FW         = $clog2(N) + 1,
   localparam int CW         = $clog2(N + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          entry_mark,
   input  logic [FW-1:0] entry_flat,
   input  logic          exit_req,
   input  logic [FW-1:0] exit_flat,
   input  logic          pwd_flag,
   output logic          exit_ready,
   output logic          exit_ok,
   output logic          exit_reject,
   output logic          gate_open,
   output logic [CW-1:0] occupied_count
);
   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int MW = 2 ** FW;
   localparam logic [FW-1:0] N_FW = FW'(N);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_RELEASE, S_REJECT, S_GATE
   } state_t;

   state_t        state_q, state_d;
   logic [N:0]    map_q, map_d;
   logic [CW-1:0] count_q, count_d;
   logic [GW-1:0] gate_cnt_q, gate_cnt_d;
   logic [FW-1:0] flat_q, flat_d;
   logic          pwd_q, pwd_d;
   logic          ready_q, ok_q, reject_q, gate_q;

   logic [MW-1:0] map_ext, set_oh, clr_oh;
   logic          set_en, clr_en;

   // Flat numbers can exceed N, so lookups go through a zero-padded copy
   // of the bitmap that covers the full flat-number range.
   assign map_ext = MW'(map_q);
   assign set_en  = entry_mark && (entry_flat <= N_FW) && !map_ext[entry_flat];
   // A same-slot mark in the release cycle keeps the slot occupied.
   assign clr_en  = (state_q == S_RELEASE) && !(entry_mark && (entry_flat == flat_q));
   assign set_oh  = set_en ? (MW'(1) << entry_flat) : '0;
   assign clr_oh  = clr_en ? (MW'(1) << flat_q) : '0;

   always_comb begin
      map_d   = (map_q & ~clr_oh[N:0]) | set_oh[N:0];
      count_d = count_q;
      if (set_en && !clr_en) count_d = count_q + CW'(1);
      else if (clr_en && !set_en) count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d    = state_q;
      flat_d     = flat_q;
      pwd_d      = pwd_q;
      gate_cnt_d = gate_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (exit_req) begin
               flat_d  = exit_flat;
               pwd_d   = pwd_flag;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (pwd_q && (flat_q <= N_FW) && map_ext[flat_q]) state_d = S_RELEASE;
            else state_d = S_REJECT;
         end
         S_RELEASE: begin
            gate_cnt_d = GW'(GATE_CYCLES - 1);
            state_d    = S_GATE;
         end
         S_REJECT: state_d = S_IDLE;
         S_GATE: begin
            if (gate_cnt_q == '0) state_d = S_IDLE;
            else gate_cnt_d = gate_cnt_q - GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line
   // up exactly with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         map_q      <= '0;
         count_q    <= '0;
         gate_cnt_q <= '0;
         flat_q     <= '0;
         pwd_q      <= 1'b0;
         ready_q    <= 1'b1;
         ok_q       <= 1'b0;
         reject_q   <= 1'b0;
         gate_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         map_q      <= map_d;
         count_q    <= count_d;
         gate_cnt_q <= gate_cnt_d;
         flat_q     <= flat_d;
         pwd_q      <= pwd_d;
         ready_q    <= (state_d == S_IDLE);
         ok_q       <= (state_d == S_RELEASE);
         reject_q   <= (state_d == S_REJECT);
         gate_q     <= (state_d == S_GATE);
      end
   end

   assign exit_ready     = ready_q;
   assign exit_ok        = ok_q;
   assign exit_reject    = reject_q;
   assign gate_open      = gate_q;
   assign occupied_count = count_q;

endmodule
